// File: rtl/my_seq_alu.sv
// Sequential ALU: single-cycle add/sub/constant ops, WIDTH-cycle unsigned shift-add multiply.
// Latency: arithmetic result 1 cycle after accept; multiply result WIDTH cycles after accept.
// Backpressure: START is ignored while BUSY=1; a DONE cycle with BUSY=0 accepts a new START.
//
// Ports:
//   CLK, RESETN         clock (rising edge) and asynchronous active-low reset
//   START, OP, A, B     request strobe, opcode {mode, ysel[1:0], cin}, operands
//   R, RH               result low / high half (RH is 0 after arithmetic ops)
//   Z, V, C4            zero, signed overflow, carry flags
//   BUSY, DONE          multiply in progress / one-cycle result-valid pulse
module my_seq_alu #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RESETN,
    input  logic             START,
    input  logic [3:0]       OP,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] R,
    output logic [WIDTH-1:0] RH,
    output logic             Z,
    output logic             V,
    output logic             C4,
    output logic             BUSY,
    output logic             DONE
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;

    logic             acc_arith;
    logic             acc_mul;
    logic             last_iter;

    // Arithmetic datapath
    logic [WIDTH-1:0] ar_y;
    logic [WIDTH:0]   ar_sum;
    logic [WIDTH-1:0] ar_low;
    logic             ar_cmsb;

    // Multiply step datapath
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] hi_nxt;
    logic [WIDTH-1:0] lo_nxt;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and accept decode
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        acc_arith = 1'b0;
        acc_mul   = 1'b0;
        last_iter = 1'b0;
        case (state)
            IDLE, FIN: begin
                acc_arith = START & ~OP[3];
                acc_mul   = START &  OP[3];
                state_nxt = acc_mul ? MUL : IDLE;
            end
            MUL: begin
                // Counter still holds 1 on the edge performing the final iteration.
                last_iter = (cnt == CW'(1));
                if (last_iter) begin
                    state_nxt = FIN;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign BUSY = (state == MUL);

    // ------------------------------------------------------------------
    // Arithmetic: A + Y + cin, with carry into the MSB for overflow
    // ------------------------------------------------------------------
    always_comb begin
        ar_y = B;
        case (OP[2:1])
            2'b00:   ar_y = B;
            2'b01:   ar_y = ~B;
            2'b10:   ar_y = '0;
            default: ar_y = '1;
        endcase
    end

    assign ar_sum  = {1'b0, A} + {1'b0, ar_y} + (WIDTH+1)'(OP[0]);
    // Sum of the low WIDTH-1 bits; its top bit is the carry into the MSB.
    assign ar_low  = {1'b0, A[WIDTH-2:0]} + {1'b0, ar_y[WIDTH-2:0]} + WIDTH'(OP[0]);
    assign ar_cmsb = ar_low[WIDTH-1];

    // ------------------------------------------------------------------
    // Multiply: {acc_hi, acc_lo} starts as {0, B}; each step conditionally
    // adds the multiplicand to the high half and shifts the pair right.
    // After WIDTH steps the pair holds the full 2*WIDTH-bit product.
    // ------------------------------------------------------------------
    assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
    assign hi_nxt  = mul_sum[WIDTH:1];
    assign lo_nxt  = {mul_sum[0], acc_lo[WIDTH-1:1]};

    // ------------------------------------------------------------------
    // Datapath and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            R      <= '0;
            RH     <= '0;
            Z      <= 1'b0;
            V      <= 1'b0;
            C4     <= 1'b0;
            DONE   <= 1'b0;
            cnt    <= '0;
            mcand  <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
        end else begin
            DONE <= 1'b0;

            if (acc_mul) begin
                mcand  <= A;
                acc_hi <= '0;
                acc_lo <= B;
                cnt    <= CW'(WIDTH);
            end else if (acc_arith) begin
                R    <= ar_sum[WIDTH-1:0];
                RH   <= '0;
                C4   <= ar_sum[WIDTH];
                V    <= ar_cmsb ^ ar_sum[WIDTH];
                Z    <= (ar_sum[WIDTH-1:0] == '0);
                DONE <= 1'b1;
            end

            if (state == MUL) begin
                acc_hi <= hi_nxt;
                acc_lo <= lo_nxt;
                cnt    <= cnt - CW'(1);
                if (last_iter) begin
                    R    <= lo_nxt;
                    RH   <= hi_nxt;
                    Z    <= ({hi_nxt, lo_nxt} == '0);
                    C4   <= (hi_nxt != '0);
                    V    <= 1'b0;
                    DONE <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_my_seq_alu.sv
// Bench for my_seq_alu (WIDTH=8): directed vectors, expected results queued
// at issue time and compared by an independent monitor on every DONE.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_my_seq_alu;

    logic       CLK = 1'b0;
    logic       RESETN;
    logic       START;
    logic [3:0] OP;
    logic [7:0] A, B;
    logic [7:0] R, RH;
    logic       Z, V, C4, BUSY, DONE;

    typedef struct {
        logic [7:0] r;
        logic [7:0] rh;
        logic       z;
        logic       v;
        logic       c4;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   busy_cnt;

    my_seq_alu #(.WIDTH(8)) dut (
        .CLK    (CLK),
        .RESETN (RESETN),
        .START  (START),
        .OP     (OP),
        .A      (A),
        .B      (B),
        .R      (R),
        .RH     (RH),
        .Z      (Z),
        .V      (V),
        .C4     (C4),
        .BUSY   (BUSY),
        .DONE   (DONE)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: every DONE must match the oldest outstanding expectation.
    always @(negedge CLK) begin
        if (DONE === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: got DONE=1 expected no pending op (t=%0t)", $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("R",       R,    e.r);
                chk("RH",      RH,   e.rh);
                chk("Z",       8'(Z),  8'(e.z));
                chk("V",       8'(V),  8'(e.v));
                chk("C4",      8'(C4), 8'(e.c4));
                chk("busy_at_done", 8'(BUSY), 8'h00);
            end
        end
    end

    // Called just after a falling edge; leaves START low one edge later.
    task automatic op1(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] r, input logic [7:0] rh,
                       input logic z, input logic v, input logic c4);
        exp_t e;
        START = 1'b1;
        OP    = op;
        A     = a;
        B     = b;
        e.r   = r;
        e.rh  = rh;
        e.z   = z;
        e.v   = v;
        e.c4  = c4;
        sb.push_back(e);
        @(negedge CLK);
        START = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_R"},    R,          8'h00);
        chk({tag, "_RH"},   RH,         8'h00);
        chk({tag, "_Z"},    8'(Z),      8'h00);
        chk({tag, "_V"},    8'(V),      8'h00);
        chk({tag, "_C4"},   8'(C4),     8'h00);
        chk({tag, "_BUSY"}, 8'(BUSY),   8'h00);
        chk({tag, "_DONE"}, 8'(DONE),   8'h00);
    endtask

    initial begin
        RESETN = 1'b0;
        START  = 1'b0;
        OP     = 4'h0;
        A      = 8'h00;
        B      = 8'h00;

        // Reset state
        repeat (3) @(negedge CLK);
        chk_all_zero("reset");
        RESETN = 1'b1;
        idle(1);

        // ADD 7F+01: signed overflow
        op1(4'b0000, 8'h7F, 8'h01, 8'h80, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("add_done_once", 8'(DONE), 8'h01);
        idle(1);
        chk("add_done_drop", 8'(DONE), 8'h00);
        idle(1);

        // SUB 05-05 -> 0 with carry; 00-01 -> FF no carry
        op1(4'b0011, 8'h05, 8'h05, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1);
        op1(4'b0011, 8'h00, 8'h01, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0);
        idle(2);

        // Constant Y: all-ones, and all-zeros with carry-in
        op1(4'b0110, 8'h00, 8'h00, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0);
        op1(4'b0101, 8'hFF, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1);
        idle(2);

        // MUL FF*FF = FE01; START with A=00 during BUSY must be ignored
        op1(4'b1000, 8'hFF, 8'hFF, 8'h01, 8'hFE, 1'b0, 1'b0, 1'b1);
        busy_cnt = 0;
        START = 1'b1;
        OP    = 4'b0000;
        A     = 8'h00;
        B     = 8'h00;
        for (int i = 0; i < 40 && (BUSY || busy_cnt == 0); i++) begin
            if (BUSY) busy_cnt++;
            if (busy_cnt == 4) START = 1'b0;
            @(negedge CLK);
        end
        START = 1'b0;
        chk("mul_busy_cycles", 8'(busy_cnt), 8'd8);
        idle(3);

        // Reset in the 3rd BUSY cycle: immediate clear, no DONE afterwards
        START = 1'b1;
        OP    = 4'b1000;
        A     = 8'h0C;
        B     = 8'h0D;
        @(negedge CLK);
        START = 1'b0;
        chk("abort_busy", 8'(BUSY), 8'h01);
        idle(2);
        #1 RESETN = 1'b0;
        #1 chk_all_zero("async_reset");
        @(negedge CLK);
        RESETN = 1'b1;
        idle(12);

        // First START after reset release
        op1(4'b0000, 8'h02, 8'h03, 8'h05, 8'h00, 1'b0, 1'b0, 1'b0);
        idle(2);

        // Back-to-back: START held, OP alternating ADD/SUB
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0)
                op1(4'b0000, 8'h10, 8'h01, 8'h11, 8'h00, 1'b0, 1'b0, 1'b0);
            else
                op1(4'b0011, 8'h10, 8'h01, 8'h0F, 8'h00, 1'b0, 1'b0, 1'b1);
            chk("b2b_done", 8'(DONE), 8'h01);
        end
        idle(3);

        chk("pending_ops", 8'(sb.size()), 8'h00);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/my_seq_alu.md
MY_SEQ_ALU -- requirements
Module: my_seq_alu

Interface
REQ-001 Parameter WIDTH, default 8: operand and result width; the block SHALL support any WIDTH >= 2.
REQ-002 Port CLK, input, 1: the single clock; all state SHALL update on the rising edge.
REQ-003 Port RESETN, input, 1: reset, asynchronous and active-low.
REQ-004 Port START, input, 1: operation request, sampled on the rising edge of CLK.
REQ-005 Port OP, input, 4: OP[3] selects mode (0 = arithmetic, 1 = multiply); OP[2:1] selects the Y operand; OP[0] is the carry-in.
REQ-006 Port A, input, WIDTH: first operand.
REQ-007 Port B, input, WIDTH: second operand.
REQ-008 Port R, output, WIDTH: registered result (low half of the product in multiply mode).
REQ-009 Port RH, output, WIDTH: registered high half of the product; 0 after any arithmetic op.
REQ-010 Port Z, output, 1: zero flag, registered.
REQ-011 Port V, output, 1: signed overflow flag, registered.
REQ-012 Port C4, output, 1: carry flag, registered.
REQ-013 Port BUSY, output, 1: high while a multiply is in progress.
REQ-014 Port DONE, output, 1: one-cycle pulse that marks new R/RH/flag values.

Function
REQ-015 The block SHALL accept START only when BUSY=0; START while BUSY=1 SHALL be ignored, and A, B and OP changes during BUSY SHALL have no effect.
REQ-016 Arithmetic op (OP[3]=0) accepted at edge k SHALL form Y from OP[2:1]: 00 -> B, 01 -> ~B, 10 -> all-zeros, 11 -> all-ones.
REQ-017 At the same edge k the block SHALL register R = (A + Y + OP[0]) mod 2^WIDTH, C4 = carry out of the MSB, V = carry into the MSB XOR carry out of the MSB, Z = (R==0), and RH = 0.
REQ-018 For an arithmetic op, DONE SHALL be 1 for the cycle after edge k only, and BUSY SHALL stay 0.
REQ-019 A multiply (OP[3]=1, OP[2:0] ignored) accepted at edge k SHALL latch A and B, set BUSY=1 and load an iteration counter with WIDTH.
REQ-020 The FSM SHALL have exactly three states, IDLE, MUL and FIN, with these transitions:
- IDLE -> MUL on an accepted multiply.
- MUL -> MUL while the counter is not 0.
- MUL -> FIN when the last iteration completes.
- FIN -> IDLE, or FIN -> MUL if another multiply is accepted.
- Arithmetic ops SHALL complete directly from IDLE or FIN.
REQ-021 In MUL, each edge SHALL perform one unsigned shift-add iteration and decrement the counter.
REQ-022 The edge that completes iteration WIDTH (edge k+WIDTH) SHALL write {RH,R} = A*B (unsigned, 2*WIDTH bits), Z = (product==0), C4 = (RH!=0), V = 0, clear BUSY and set DONE for one cycle.
REQ-023 BUSY SHALL be high for exactly WIDTH cycles per multiply.
REQ-024 START in a DONE cycle with BUSY=0 SHALL be accepted, so that back-to-back operations have no idle cycle.
REQ-025 R, RH and the flags SHALL hold their values until the next completion.
REQ-026 DONE SHALL never be high for two consecutive cycles from a single operation.

Reset
REQ-027 While RESETN=0, R, RH, Z, V, C4, BUSY and DONE SHALL be 0 and the FSM SHALL be in IDLE, independent of CLK.
REQ-028 Reset asserted mid-multiply SHALL abort the multiply with no DONE pulse.
REQ-029 The first START sampled after RESETN rises SHALL be accepted normally.

Verification (WIDTH=8)
REQ-030 ADD: OP=0000, A=7F, B=01 -> next cycle R=80, V=1, C4=0, Z=0, RH=00, DONE=1 for one cycle, BUSY=0.
REQ-031 SUB: OP=0011, A=05, B=05 -> R=00, Z=1, C4=1, V=0; then A=00, B=01 -> R=FF, C4=0, V=0.
REQ-032 Constants: OP=0110, A=00 -> R=FF, C4=0; OP=0101, A=FF -> R=00, C4=1, Z=1.
REQ-033 MUL: OP=1000, A=FF, B=FF -> BUSY=1 for 8 cycles, then R=01, RH=FE, C4=1, V=0, Z=0 with a single DONE; a START with A=00 during BUSY is ignored.
REQ-034 Reset: RESETN=0 in the 3rd BUSY cycle -> all outputs 0 immediately with no DONE; after release, ADD A=02, B=03 -> R=05.
REQ-035 Back-to-back: START held high with OP alternating 0000/0011, A=10, B=01 -> DONE every cycle, R alternating 11/0F.
